gb_apu_length_bank: RTL and testbench
=====================================

// Module: gb_apu_length_bank
// PURPOSE
//   Multi-channel length-timer bank for the APU; replaces per-channel length blocks.
//   One down-counter per channel, loaded from NRx1 writes and clocked by the frame-sequencer length tick.
//   Gates each channel's enable; sits between register file/frame sequencer and channel mixers.
// PARAMETERS
//   NUM_CH     4        number of channels served
//   WIDTH_MAX  8        widest length field; sizes length_data
//   LONG_MASK  4'b0100  bit i=1: channel i uses a WIDTH_MAX-bit length (CH3), else 6-bit
// PORTS
//   clk             in   1               system clock
//   reset_n         in   1               asynchronous, active-low reset
//   clk_length_ctr  in   1               1-cycle length tick from the frame sequencer (256 Hz)
//   fs_len_next     in   1               high when the next frame-sequencer step clocks length
//   apu_on          in   1               NR52 master enable
//   load            in   NUM_CH          per-channel length-register write strobe
//   length_data     in   WIDTH_MAX       written length value; 6-bit channels use [5:0]
//   len_en          in   NUM_CH          per-channel length enable (NRx4 bit 6), level
//   trig            in   NUM_CH          per-channel trigger strobe (NRx4 bit 7 write)
//   dac_on          in   NUM_CH          per-channel DAC power
//   enable          out  NUM_CH          channel active
//   expired         out  NUM_CH          1-cycle pulse when a counter reaches 0 and disables its channel
// BEHAVIOUR
//   - Per channel: W = 8 if LONG_MASK[i] else 6; counter cnt_i holds W+1 bits, range 0..2^W.
//   - Reset (reset_n=0, async): enable=0, expired=0, all cnt_i=0, len_en history=0.
//   - Load: load[i] -> cnt_i <= 2^W - length_data[W-1:0] (0 -> 2^W, 63 -> 1 for W=6); enable unchanged.
//   - Tick: clk_length_ctr && len_en[i] && cnt_i!=0 -> cnt_i-1; on 1->0: enable[i]<=0, expired[i]=1 one cycle.
//   - Tick with cnt_i==0: no change. Tick with len_en[i]=0: counter holds.
//   - Trigger: trig[i] -> enable[i]<=dac_on[i]; if cnt_i==0 then cnt_i<=2^W, else unchanged.
//   - dac_on[i]=0: enable[i]<=0 next cycle; counter keeps counting (not reset).
//   - apu_on=0: enable=0, all cnt_i=0; load/trig/tick ignored while low.
//   - Same-cycle priority per channel: load > trig > tick (no decrement on a load or trigger cycle).
//   - load and trig same cycle: cnt_i takes load value (trigger's 0->2^W reload not applied);
//     enable per trigger rule.
//   - Channels independent; any combination of strobes across channels honoured in one cycle.
//   - Latency: all outputs registered, 1 cycle after the causing strobe/tick.
// CONFIGURATION
//   LENGTH_EXTRA_CLK_EN defined: hardware length quirks modelled:
//     - len_en[i] rising (0->1, sampled vs prior cycle) while fs_len_next=0 and cnt_i!=0:
//       extra decrement; if it reaches 0 and trig[i]=0, enable[i]<=0, expired[i] pulses.
//     - trig[i] with cnt_i==0, len_en[i]=1, fs_len_next=0: reload to 2^W-1 instead of 2^W.
//   Undefined: fs_len_next ignored; only rules above apply; len_en history register removed.
// TESTING
//   1) CH1 load 0, trig, len_en=1, 64 ticks -> enable[0] falls after 64th tick, expired[0] pulses once.
//   2) CH3 load 200, trig, len_en=1 -> expires after exactly 56 ticks; CH1 idle unaffected.
//   3) Expired CH2, trig again, no load -> cnt=64, enable=1; len_en=0 + 100 ticks -> stays enabled.
//   4) load+trig+tick same cycle on CH4 length 10 -> cnt=54, no decrement, enable=1.
//   5) apu_on=0 mid-count, then reset_n low mid-count -> all enables 0, counters 0, no expired pulse.
//   6) EXTRA_CLK_EN: cnt=1, len_en 0->1 with fs_len_next=0 -> enable drops next cycle;
//      with fs_len_next=1 -> holds until next tick.

Source files
------------

// File: rtl/gb_apu_length_bank.sv
// gb_apu_length_bank: multi-channel APU length-timer bank.
// Each channel owns a down-counter.
// - An NRx1 write loads the counter.
// - The frame-sequencer length tick decrements it while the channel's length enable is set.
// - The counter going from 1 to 0 drops the channel enable and pulses expired for one cycle.
// 6-bit channels count over 0..64. Channels flagged in LONG_MASK count over 0..2^WIDTH_MAX.
// Optional build macro LENGTH_EXTRA_CLK_EN models two hardware length quirks:
// - A rising len_en outside a length step causes an extra decrement.
// - A trigger of an empty counter outside a length step reloads to one below full.
// Without the macro, fs_len_next is ignored and the len_en history flops are not built.
module gb_apu_length_bank #(
   parameter int                NUM_CH    = 4,
   parameter int                WIDTH_MAX = 8,
   parameter logic [NUM_CH-1:0] LONG_MASK = 4'b0100
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 clk_length_ctr,
   input  logic                 fs_len_next,
   input  logic                 apu_on,
   input  logic [NUM_CH-1:0]    load,
   input  logic [WIDTH_MAX-1:0] length_data,
   input  logic [NUM_CH-1:0]    len_en,
   input  logic [NUM_CH-1:0]    trig,
   input  logic [NUM_CH-1:0]    dac_on,
   output logic [NUM_CH-1:0]    enable,
   output logic [NUM_CH-1:0]    expired
);

   // One extra bit so a full counter (2^W) is representable.
   localparam int CW = WIDTH_MAX + 1;

`ifndef LENGTH_EXTRA_CLK_EN
   // Frame-sequencer lookahead only matters for the quirk model.
   logic unused_fs_len_next;
   assign unused_fs_len_next = fs_len_next;
`endif

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      localparam int             W    = LONG_MASK[i] ? WIDTH_MAX : 6;
      localparam logic [CW-1:0]  FULL = CW'(1) << W;

      logic [CW-1:0] data_v;
      logic [CW-1:0] reload_v;
      logic [CW-1:0] cnt_pre;
      logic          extra_clk;
      logic [CW-1:0] cnt_q, cnt_d;
      logic          en_q, en_d;
      logic          exp_q, exp_d;
      logic          kill;

      // Only the channel's own length field width is significant.
      if (LONG_MASK[i]) begin : g_long
         assign data_v = CW'(length_data);
      end else begin : g_short
         assign data_v = CW'(length_data[5:0]);
      end

`ifdef LENGTH_EXTRA_CLK_EN
      logic len_en_q;

      // Previous-cycle len_en, used to detect a 0->1 enable write.
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) len_en_q <= 1'b0;
         else          len_en_q <= len_en[i];
      end

      // A load always wins, so the extra clock is suppressed on a load cycle.
      assign extra_clk = len_en[i] & ~len_en_q & ~fs_len_next & (cnt_q != '0) & ~load[i];
      assign reload_v  = (len_en[i] & ~fs_len_next) ? (FULL - CW'(1)) : FULL;
`else
      assign extra_clk = 1'b0;
      assign reload_v  = FULL;
`endif

      // Counter value after any quirk decrement and before trigger reload.
      assign cnt_pre = extra_clk ? (cnt_q - CW'(1)) : cnt_q;

      // Per-channel next state. Priority is load > trigger > tick; the master enable overrides all.
      always_comb begin
         cnt_d = cnt_q;
         en_d  = en_q;
         exp_d = 1'b0;
         kill  = 1'b0;
         if (!apu_on) begin
            cnt_d = '0;
            en_d  = 1'b0;
         end else begin
            if (load[i]) begin
               cnt_d = FULL - data_v;
            end else if (trig[i]) begin
               cnt_d = (cnt_pre == '0) ? reload_v : cnt_pre;
            end else if (extra_clk) begin
               cnt_d = cnt_pre;
               kill  = (cnt_pre == '0);
            end else if (clk_length_ctr && len_en[i] && (cnt_q != '0)) begin
               cnt_d = cnt_q - CW'(1);
               kill  = (cnt_q == CW'(1));
            end

            if (trig[i])                 en_d = dac_on[i];
            else if (kill || !dac_on[i]) en_d = 1'b0;
            exp_d = kill;
         end
      end

      // Counter, enable and expiry pulse registers.
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            cnt_q <= '0;
            en_q  <= 1'b0;
            exp_q <= 1'b0;
         end else begin
            cnt_q <= cnt_d;
            en_q  <= en_d;
            exp_q <= exp_d;
         end
      end

      assign enable[i]  = en_q;
      assign expired[i] = exp_q;
   end

endmodule

// File: tb/tb_gb_apu_length_bank.sv
// tb_gb_apu_length_bank: directed bench for the APU length-timer bank.
// Internal counters are observed through enable/expired timing.
module tb_gb_apu_length_bank;

   logic       clk;
   logic       reset_n;
   logic       clk_length_ctr;
   logic       fs_len_next;
   logic       apu_on;
   logic [3:0] load;
   logic [7:0] length_data;
   logic [3:0] len_en;
   logic [3:0] trig;
   logic [3:0] dac_on;
   logic [3:0] enable;
   logic [3:0] expired;

   int checks = 0;
   int errors = 0;

   gb_apu_length_bank dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .clk_length_ctr (clk_length_ctr),
      .fs_len_next    (fs_len_next),
      .apu_on         (apu_on),
      .load           (load),
      .length_data    (length_data),
      .len_en         (len_en),
      .trig           (trig),
      .dac_on         (dac_on),
      .enable         (enable),
      .expired        (expired)
   );

   // Clock and watchdog
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required finish before 500us");
      $fatal(1, "watchdog");
   end

   // Advance one clock; outputs are sampled 1 ns after the edge.
   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic tick();
      clk_length_ctr = 1'b1;
      cycle();
      clk_length_ctr = 1'b0;
   endtask

   task automatic do_load(input logic [3:0] ch, input logic [7:0] data);
      load = ch;
      length_data = data;
      cycle();
      load = '0;
   endtask

   task automatic do_trig(input logic [3:0] ch);
      trig = ch;
      cycle();
      trig = '0;
   endtask

   task automatic apply_reset();
      reset_n = 1'b0;
      clk_length_ctr = 1'b0;
      fs_len_next = 1'b1;
      apu_on = 1'b1;
      load = '0;
      length_data = '0;
      len_en = '0;
      trig = '0;
      dac_on = 4'b1111;
      cycle();
      reset_n = 1'b1;
      cycle();
   endtask

   task automatic test_reset();
      apply_reset();
      reset_n = 1'b0;
      #1;
      checks++;
      if (enable !== 4'b0000 || expired !== 4'b0000) begin
         errors++;
         $display("FAIL reset_outputs: enable=%b expired=%b, required 0000/0000", enable, expired);
      end
      cycle();
      reset_n = 1'b1;
      cycle();
      checks++;
      if (enable !== 4'b0000) begin
         errors++;
         $display("FAIL reset_release: enable=%b, required 0000", enable);
      end
      do_load(4'b0001, 8'd0);
      checks++;
      if (enable !== 4'b0000) begin
         errors++;
         $display("FAIL load_no_enable: enable=%b, required 0000", enable);
      end
   endtask

   // CH1 loaded with 0 runs the full 64 ticks.
   task automatic test_ch1_full();
      apply_reset();
      do_load(4'b0001, 8'd0);
      do_trig(4'b0001);
      checks++;
      if (enable !== 4'b0001) begin
         errors++;
         $display("FAIL ch1_trig_enable: enable=%b, required 0001", enable);
      end
      len_en = 4'b0001;
      cycle();
      for (int k = 1; k <= 64; k++) begin
         tick();
         checks++;
         if (enable[0] !== (k < 64) || expired[0] !== (k == 64)) begin
            errors++;
            $display("FAIL ch1_tick%0d: enable0=%b expired0=%b, required %b/%b",
                     k, enable[0], expired[0], (k < 64), (k == 64));
         end
      end
      cycle();
      checks++;
      if (expired !== 4'b0000 || enable !== 4'b0000) begin
         errors++;
         $display("FAIL ch1_pulse_once: enable=%b expired=%b, required 0000/0000", enable, expired);
      end
      tick();
      checks++;
      if (expired !== 4'b0000) begin
         errors++;
         $display("FAIL ch1_tick_at_zero: expired=%b, required 0000", expired);
      end
   endtask

   // CH3 is the long channel: 256-200 = 56 ticks, and idle CH1 stays quiet.
   task automatic test_ch3_long();
      apply_reset();
      do_load(4'b0100, 8'd200);
      do_trig(4'b0100);
      len_en = 4'b0101;
      cycle();
      for (int k = 1; k <= 56; k++) begin
         tick();
         checks++;
         if (enable !== ((k < 56) ? 4'b0100 : 4'b0000) ||
             expired !== ((k == 56) ? 4'b0100 : 4'b0000)) begin
            errors++;
            $display("FAIL ch3_tick%0d: enable=%b expired=%b", k, enable, expired);
         end
      end
   endtask

   // Retrigger of an expired CH2 reloads 64; counting pauses while len_en is low.
   task automatic test_retrigger();
      apply_reset();
      do_load(4'b0010, 8'd63);
      do_trig(4'b0010);
      len_en = 4'b0010;
      cycle();
      tick();
      checks++;
      if (enable !== 4'b0000 || expired !== 4'b0010) begin
         errors++;
         $display("FAIL ch2_len63: enable=%b expired=%b, required 0000/0010", enable, expired);
      end
      do_trig(4'b0010);
      checks++;
      if (enable !== 4'b0010) begin
         errors++;
         $display("FAIL ch2_retrig: enable=%b, required 0010", enable);
      end
      len_en = 4'b0000;
      for (int k = 1; k <= 100; k++) begin
         tick();
         checks++;
         if (enable !== 4'b0010 || expired !== 4'b0000) begin
            errors++;
            $display("FAIL ch2_hold%0d: enable=%b expired=%b, required 0010/0000", k, enable, expired);
         end
      end
      len_en = 4'b0010;
      for (int k = 1; k <= 64; k++) begin
         tick();
         checks++;
         if (enable[1] !== (k < 64) || expired[1] !== (k == 64)) begin
            errors++;
            $display("FAIL ch2_count%0d: enable1=%b expired1=%b", k, enable[1], expired[1]);
         end
      end
   endtask

   // Load, trigger and tick together on CH4: 64-10 = 54, no decrement.
   task automatic test_same_cycle();
      apply_reset();
      len_en = 4'b1000;
      cycle();
      load = 4'b1000;
      trig = 4'b1000;
      length_data = 8'd10;
      clk_length_ctr = 1'b1;
      cycle();
      load = '0;
      trig = '0;
      clk_length_ctr = 1'b0;
      checks++;
      if (enable !== 4'b1000 || expired !== 4'b0000) begin
         errors++;
         $display("FAIL ch4_same_cycle: enable=%b expired=%b, required 1000/0000", enable, expired);
      end
      for (int k = 1; k <= 54; k++) begin
         tick();
         checks++;
         if (enable[3] !== (k < 54) || expired[3] !== (k == 54)) begin
            errors++;
            $display("FAIL ch4_tick%0d: enable3=%b expired3=%b", k, enable[3], expired[3]);
         end
      end
   endtask

   // DAC off drops enable but the counter keeps running.
   task automatic test_dac_off();
      apply_reset();
      do_load(4'b0001, 8'd60);
      do_trig(4'b0001);
      len_en = 4'b0001;
      tick();
      tick();
      dac_on = 4'b1110;
      cycle();
      checks++;
      if (enable !== 4'b0000) begin
         errors++;
         $display("FAIL dac_off_drop: enable=%b, required 0000", enable);
      end
      do_trig(4'b0001);
      checks++;
      if (enable !== 4'b0000) begin
         errors++;
         $display("FAIL dac_off_trig: enable=%b, required 0000", enable);
      end
      tick();
      checks++;
      if (expired !== 4'b0000) begin
         errors++;
         $display("FAIL dac_off_count: expired=%b, required 0000", expired);
      end
      dac_on = 4'b1111;
      do_trig(4'b0001);
      checks++;
      if (enable !== 4'b0001) begin
         errors++;
         $display("FAIL dac_on_retrig: enable=%b, required 0001", enable);
      end
      tick();
      checks++;
      if (enable !== 4'b0000 || expired !== 4'b0001) begin
         errors++;
         $display("FAIL dac_kept_count: enable=%b expired=%b, required 0000/0001", enable, expired);
      end
   endtask

   // Master disable and async reset clear everything mid-count.
   task automatic test_apu_off();
      apply_reset();
      do_load(4'b0001, 8'd0);
      do_trig(4'b0001);
      len_en = 4'b0001;
      repeat (10) tick();
      apu_on = 1'b0;
      cycle();
      checks++;
      if (enable !== 4'b0000 || expired !== 4'b0000) begin
         errors++;
         $display("FAIL apu_off: enable=%b expired=%b, required 0000/0000", enable, expired);
      end
      load = 4'b0001;
      length_data = 8'd63;
      trig = 4'b0001;
      clk_length_ctr = 1'b1;
      cycle();
      load = '0;
      trig = '0;
      clk_length_ctr = 1'b0;
      checks++;
      if (enable !== 4'b0000) begin
         errors++;
         $display("FAIL apu_off_ignore: enable=%b, required 0000", enable);
      end
      apu_on = 1'b1;
      cycle();
      do_trig(4'b0001);
      for (int k = 1; k <= 64; k++) begin
         tick();
         checks++;
         if (enable[0] !== (k < 64) || expired[0] !== (k == 64)) begin
            errors++;
            $display("FAIL apu_cleared_tick%0d: enable0=%b expired0=%b", k, enable[0], expired[0]);
         end
      end
      do_load(4'b0100, 8'd0);
      do_trig(4'b0100);
      len_en = 4'b0100;
      repeat (10) tick();
      #3;
      reset_n = 1'b0;
      #1;
      checks++;
      if (enable !== 4'b0000 || expired !== 4'b0000) begin
         errors++;
         $display("FAIL async_reset: enable=%b expired=%b, required 0000/0000", enable, expired);
      end
      cycle();
      reset_n = 1'b1;
      cycle();
      do_trig(4'b0100);
      for (int k = 1; k <= 256; k++) begin
         tick();
         checks++;
         if (enable[2] !== (k < 256) || expired[2] !== (k == 256)) begin
            errors++;
            $display("FAIL reset_cleared_tick%0d: enable2=%b expired2=%b", k, enable[2], expired[2]);
         end
      end
   endtask

   // All channels strobed together; 62 gives 2 ticks on short channels, 194 on CH3.
   task automatic test_back_to_back();
      apply_reset();
      do_load(4'b1111, 8'd62);
      do_trig(4'b1111);
      len_en = 4'b1111;
      tick();
      checks++;
      if (enable !== 4'b1111 || expired !== 4'b0000) begin
         errors++;
         $display("FAIL multi_tick1: enable=%b expired=%b, required 1111/0000", enable, expired);
      end
      tick();
      checks++;
      if (enable !== 4'b0100 || expired !== 4'b1011) begin
         errors++;
         $display("FAIL multi_tick2: enable=%b expired=%b, required 0100/1011", enable, expired);
      end
      tick();
      checks++;
      if (enable !== 4'b0100 || expired !== 4'b0000) begin
         errors++;
         $display("FAIL multi_tick3: enable=%b expired=%b, required 0100/0000", enable, expired);
      end
   endtask

   // len_en rising edge outside a length step, and with a length step pending.
   task automatic test_len_en_rise();
      apply_reset();
      do_load(4'b0001, 8'd63);
      do_trig(4'b0001);
      len_en = 4'b0000;
      cycle();
      fs_len_next = 1'b0;
      len_en = 4'b0001;
      cycle();
`ifdef LENGTH_EXTRA_CLK_EN
      checks++;
      if (enable !== 4'b0000 || expired !== 4'b0001) begin
         errors++;
         $display("FAIL extra_clk: enable=%b expired=%b, required 0000/0001", enable, expired);
      end
      do_trig(4'b0001);
      for (int k = 1; k <= 63; k++) begin
         tick();
         checks++;
         if (enable[0] !== (k < 63) || expired[0] !== (k == 63)) begin
            errors++;
            $display("FAIL quirk_reload_tick%0d: enable0=%b expired0=%b", k, enable[0], expired[0]);
         end
      end
`else
      checks++;
      if (enable !== 4'b0001 || expired !== 4'b0000) begin
         errors++;
         $display("FAIL no_extra_clk: enable=%b expired=%b, required 0001/0000", enable, expired);
      end
`endif
      fs_len_next = 1'b1;
      do_load(4'b0001, 8'd63);
      do_trig(4'b0001);
      len_en = 4'b0000;
      cycle();
      len_en = 4'b0001;
      cycle();
      checks++;
      if (enable !== 4'b0001 || expired !== 4'b0000) begin
         errors++;
         $display("FAIL rise_fs_next: enable=%b expired=%b, required 0001/0000", enable, expired);
      end
      tick();
      checks++;
      if (enable !== 4'b0000 || expired !== 4'b0001) begin
         errors++;
         $display("FAIL rise_then_tick: enable=%b expired=%b, required 0000/0001", enable, expired);
      end
   endtask

   // Test sequence and final report
   initial begin
      test_reset();
      test_ch1_full();
      test_ch3_long();
      test_retrigger();
      test_same_cycle();
      test_dac_off();
      test_apu_off();
      test_back_to_back();
      test_len_en_rise();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
